// File: rtl/module_bin2bcd_seq.sv
// Sequential double-dabble converter: two's-complement (or unsigned) product to packed BCD + sign.
// Optional feature macro: BIN2BCD_SIGNED_EN (defined = signed input, undefined = unsigned).
module module_bin2bcd_seq #(
  parameter int N_BITS   = 16,
  parameter int N_DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_BITS-1:0]     product,
  output logic [4*N_DIGITS-1:0] bcd,
  output logic                  sign,
  output logic                  busy,
  output logic                  valid
);
  localparam int BW = 4 * N_DIGITS;
  localparam int CW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    LOAD  = 4'b0010,
    SHIFT = 4'b0100,
    DONE  = 4'b1000
  } state_e;

  state_e            state_q, state_d;
  logic [N_BITS-1:0] raw_q, raw_d;
  logic [N_BITS-1:0] mag_q, mag_d;
  logic [BW-1:0]     scratch_q, scratch_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic              sign_r_q, sign_r_d;
  logic              sign_q, sign_d;

  logic              neg;
  logic [N_BITS-1:0] mag_load;
  logic [BW-1:0]     scratch_adj;
  logic [BW-1:0]     scratch_shl;
  logic              last_shift;

`ifdef BIN2BCD_SIGNED_EN
  // Negating the most negative value wraps to 2^(N_BITS-1), which is the right unsigned magnitude.
  assign neg      = raw_q[N_BITS-1];
  assign mag_load = neg ? (~raw_q + {{(N_BITS-1){1'b0}}, 1'b1}) : raw_q;
`else
  assign neg      = 1'b0;
  assign mag_load = raw_q;
`endif

  always_comb begin
    scratch_adj = scratch_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (scratch_q[i*4 +: 4] >= 4'd5)
        scratch_adj[i*4 +: 4] = scratch_q[i*4 +: 4] + 4'd3;
    end
  end

  assign scratch_shl = {scratch_adj[BW-2:0], mag_q[N_BITS-1]};
  assign last_shift  = (state_q == SHIFT) && (cnt_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from flops, no input-to-output paths
  always_comb begin
    busy  = (state_q != IDLE);
    valid = (state_q == DONE);
    bcd   = bcd_q;
    sign  = sign_q;
  end

  always_comb begin
    raw_d     = raw_q;
    mag_d     = mag_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    sign_r_d  = sign_r_q;
    bcd_d     = bcd_q;
    sign_d    = sign_q;
    case (state_q)
      IDLE: if (start) raw_d = product;
      LOAD: begin
        sign_r_d  = neg;
        mag_d     = mag_load;
        scratch_d = '0;
        cnt_d     = CW'(N_BITS - 1);
      end
      SHIFT: begin
        scratch_d = scratch_shl;
        mag_d     = {mag_q[N_BITS-2:0], 1'b0};
        cnt_d     = cnt_q - 1'b1;
      end
      default: ;
    endcase
    // Result is captured on the edge entering DONE so it is visible alongside valid
    if (last_shift) begin
      bcd_d  = scratch_shl;
      sign_d = sign_r_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q     <= '0;
      mag_q     <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      sign_r_q  <= 1'b0;
      bcd_q     <= '0;
      sign_q    <= 1'b0;
    end else begin
      raw_q     <= raw_d;
      mag_q     <= mag_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      sign_r_q  <= sign_r_d;
      bcd_q     <= bcd_d;
      sign_q    <= sign_d;
    end
  end

endmodule

// File: tb/tb_module_bin2bcd_seq.sv
// Scoreboard bench for module_bin2bcd_seq; expected BCD comes from a decimal model, checked on valid.
module tb_module_bin2bcd_seq;
  localparam int N  = 16;
  localparam int D  = 5;
  localparam int BW = 4 * D;

  typedef struct {
    logic [BW-1:0] bcd;
    logic          sign;
  } res_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [N-1:0]  product = '0;
  logic [BW-1:0] bcd;
  logic          sign, busy, valid;

  res_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   n_valid = 0;

  module_bin2bcd_seq #(.N_BITS(N), .N_DIGITS(D)) dut (
    .clk(clk), .rst(rst), .start(start), .product(product),
    .bcd(bcd), .sign(sign), .busy(busy), .valid(valid)
  );

  always #5 clk = ~clk;

  function automatic res_t model(input logic [N-1:0] p);
    res_t   r;
    longint m;
    m      = longint'(p);
    r.sign = 1'b0;
`ifdef BIN2BCD_SIGNED_EN
    if (p[N-1]) begin
      r.sign = 1'b1;
      m      = (longint'(1) << N) - m;
    end
`endif
    r.bcd = '0;
    for (int i = 0; i < D; i++) begin
      r.bcd[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  // Scoreboard consumer
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      res_t e;
      n_valid++;
      n_chk++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: got bcd=%h sign=%b, required no valid", bcd, sign);
      end else begin
        e = sb.pop_front();
        if (bcd !== e.bcd || sign !== e.sign) begin
          n_fail++;
          $display("FAIL result: got bcd=%h sign=%b, required bcd=%h sign=%b", bcd, sign, e.bcd, e.sign);
        end
      end
    end
  end

  // Present p with start high across one accepting edge; returns #1 into cycle 1
  task automatic go(input logic [N-1:0] p);
    @(posedge clk); #1;
    product = p;
    start   = 1'b1;
    sb.push_back(model(p));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_chk++; if (bcd   !== '0)   begin n_fail++; $display("FAIL reset_bcd: got %h, required 0", bcd); end
    n_chk++; if (sign  !== 1'b0) begin n_fail++; $display("FAIL reset_sign: got %b, required 0", sign); end
    n_chk++; if (busy  !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
    rst = 1'b0;
  endtask

  task automatic test_zero_timing;
    go('0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      n_chk++;
      if (busy !== (k <= 18) || valid !== (k == 18)) begin
        n_fail++;
        $display("FAIL zero_timing cycle %0d: got busy=%b valid=%b, required busy=%b valid=%b",
                 k, busy, valid, (k <= 18), (k == 18));
      end
    end
  endtask

  task automatic test_values;
    logic [N-1:0] vals[8];
    vals = '{16'hFF9C, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h1234, 16'h0001, 16'h270F, 16'hC350};
    foreach (vals[i]) begin
      go(vals[i]);
      repeat (20) @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int   v0;
    res_t a;
    a  = model(16'h0929);
    v0 = n_valid;
    go(16'h0929);
    for (int k = 1; k <= 40; k++) begin
      if (k == 5 || k == 18) begin start = 1'b1; product = 16'h4321; end
      else                   begin start = 1'b0; product = 16'h0929; end
      @(negedge clk);
      n_chk++;
      if (valid !== (k == 18) || busy !== (k <= 18)) begin
        n_fail++;
        $display("FAIL ignore_start cycle %0d: got busy=%b valid=%b, required busy=%b valid=%b",
                 k, busy, valid, (k <= 18), (k == 18));
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    n_chk++;
    if (n_valid - v0 != 1) begin n_fail++; $display("FAIL ignore_count: got %0d valids, required 1", n_valid - v0); end
    n_chk++;
    if (bcd !== a.bcd || sign !== a.sign) begin
      n_fail++; $display("FAIL ignore_hold: got bcd=%h sign=%b, required bcd=%h sign=%b", bcd, sign, a.bcd, a.sign);
    end
  endtask

  task automatic test_reset_mid;
    go(16'h1234);
    repeat (10) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    n_chk++;
    if (busy !== 1'b0 || valid !== 1'b0 || bcd !== '0 || sign !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b valid=%b bcd=%h sign=%b, required all 0", busy, valid, bcd, sign);
    end
    void'(sb.pop_back());
    @(posedge clk); #1 rst = 1'b0;
    go(16'h1234);
    repeat (20) @(negedge clk);
    n_chk++;
    if (bcd !== 20'h04660) begin n_fail++; $display("FAIL after_reset: got %h, required 04660", bcd); end
  endtask

  task automatic test_back_to_back;
    @(posedge clk); #1;
    product = 16'h0457; start = 1'b1; sb.push_back(model(16'h0457));
    @(posedge clk); #1;
    product = 16'hF000; sb.push_back(model(16'hF000));
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      n_chk++;
      if (valid !== (k % 19 == 18 && k <= 56)) begin
        n_fail++;
        $display("FAIL back_to_back cycle %0d: got valid=%b, required %b", k, valid, (k % 19 == 18 && k <= 56));
      end
      @(posedge clk); #1;
      if (k == 19) begin product = 16'h2710; sb.push_back(model(16'h2710)); end
      if (k == 38) begin start = 1'b0; product = 16'hAAAA; end
    end
  endtask

  initial begin
    test_reset();
    test_zero_timing();
    test_values();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    n_chk++;
    if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
